spm_seq_ctrl: RTL

- Sequencing wrapper for the serial-parallel multiplier (spm) datapath, placed directly upstream and downstream of the carry-save adder chain (csa0..csaN).
- Accepts a parallel operand pair on a valid/ready handshake and holds x in parallel for the CSA cells.
- Serializes y LSB-first into the chain, collects the serial product bits from csa0's sum output, and presents the full 2*WIDTH product on a second valid/ready handshake.
- Contains its own WIDTH-cell CSA chain, so the block is self-contained.

---
 rtl/spm_seq_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/spm_seq_ctrl.sv
// spm_seq_ctrl: handshake sequencer around a serial-parallel signed multiplier CSA chain
module spm_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_q, y_sh, s, c;
    logic [WIDTH-1:0] pp, addend, s_in, sum_v, car_v;
    logic [PW-1:0]    p_sh, p_next;
    logic [CW-1:0]    cnt;
    logic             seen, ybit, nbit;

    // CSA chain: cells 0..W-2 add their partial product to the neighbour's sum;
    // the top cell adds the serially negated MSB partial product (weight -2^(W-1))
    always_comb begin
        ybit   = y_sh[0];
        pp     = x_q & {WIDTH{ybit}};
        nbit   = pp[WIDTH-1] ^ seen;
        addend = {nbit, pp[WIDTH-2:0]};
        s_in   = {1'b0, s[WIDTH-1:1]};
        sum_v  = addend ^ s_in ^ c;
        car_v  = (addend & s_in) | (addend & c) | (s_in & c);
        p_next = {sum_v[0], p_sh[PW-1:1]};
    end

    // sequencer FSM with registered handshake outputs and the chain's state flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
            x_q       <= '0;
            y_sh      <= '0;
            s         <= '0;
            c         <= '0;
            seen      <= 1'b0;
            p_sh      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_q      <= x;
                    y_sh     <= y;
                    s        <= '0;
                    c        <= '0;
                    seen     <= 1'b0;
                    p_sh     <= '0;
                    cnt      <= '0;
                    state    <= RUN;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                RUN: begin
                    s    <= sum_v;
                    c    <= car_v;
                    seen <= seen | pp[WIDTH-1];
                    y_sh <= {y_sh[WIDTH-1], y_sh[WIDTH-1:1]};
                    p_sh <= p_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(PW - 1)) begin
                        p         <= p_next;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
